// File: rtl/cordic_input_mapping_pkg.sv
// Shared definitions for the CORDIC pre-rotation input mapper and the matching output mapper.
package cordic_input_mapping_pkg;

  localparam int unsigned CORDIC_W = 20;

  localparam logic [2:0] QUAD_1 = 3'd1;
  localparam logic [2:0] QUAD_2 = 3'd2;
  localparam logic [2:0] QUAD_3 = 3'd3;
  localparam logic [2:0] QUAD_4 = 3'd4;

  // Zero is treated as non-negative, so the axes fall into Q1, Q2 or Q4.
  function automatic logic [2:0] classify_quad(input logic x_neg, input logic y_neg);
    logic [2:0] q;
    unique case ({x_neg, y_neg})
      2'b00:   q = QUAD_1;
      2'b10:   q = QUAD_2;
      2'b11:   q = QUAD_3;
      default: q = QUAD_4;
    endcase
    return q;
  endfunction

endpackage

// File: rtl/cordic_sat_negate.sv
// Combinational two's-complement negate; flags the most-negative input and
// either saturates it to the most-positive value or lets it wrap.
module cordic_sat_negate #(
  parameter int unsigned W      = 20,
  parameter bit          SAT_EN = 1'b1
) (
  input  logic signed [W-1:0] a_i,
  output logic signed [W-1:0] neg_o,
  output logic                sat_o
);

  localparam logic [W-1:0] MinVal = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MaxVal = ~MinVal;

  always_comb begin
    sat_o = (a_i == MinVal);
    neg_o = -a_i;
    if (sat_o) begin
      neg_o = SAT_EN ? MaxVal : MinVal;
    end
  end

endmodule

// File: rtl/cordic_input_mapping.sv
// Two-stage valid/ready pre-rotation: stage 1 classifies the quadrant, stage 2 folds the
// vector into the right half-plane and tags it for the downstream output mapper.
module cordic_input_mapping
  import cordic_input_mapping_pkg::*;
#(
  parameter int unsigned W      = CORDIC_W,
  parameter bit          SAT_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] x_in,
  input  logic signed [W-1:0] y_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] x_map,
  output logic signed [W-1:0] y_map,
  output logic [2:0]          quadrant_loc,
  output logic                sat_flag,
  output logic [15:0]         sat_count
);

  logic                s1_valid_q;
  logic signed [W-1:0] s1_x_q, s1_y_q;
  logic [2:0]          s1_quad_q;

  logic                s2_valid_q;
  logic signed [W-1:0] x_map_q, y_map_q;
  logic [2:0]          quad_q;
  logic                sat_flag_q;
  logic [15:0]         sat_count_q, sat_count_d;

  logic s1_adv, s2_adv, out_xfer;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;
  assign out_xfer = s2_valid_q && out_ready;

  // Stage 1: capture and classify.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_quad_q  <= QUAD_1;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_x_q    <= x_in;
        s1_y_q    <= y_in;
        s1_quad_q <= classify_quad(x_in[W-1], y_in[W-1]);
      end
    end
  end

  logic signed [W-1:0] neg_x, neg_y;
  logic                neg_x_sat, neg_y_sat;

  cordic_sat_negate #(
    .W      (W),
    .SAT_EN (SAT_EN)
  ) u_neg_x (
    .a_i   (s1_x_q),
    .neg_o (neg_x),
    .sat_o (neg_x_sat)
  );

  cordic_sat_negate #(
    .W      (W),
    .SAT_EN (SAT_EN)
  ) u_neg_y (
    .a_i   (s1_y_q),
    .neg_o (neg_y),
    .sat_o (neg_y_sat)
  );

  logic signed [W-1:0] fold_x, fold_y;
  logic                fold_sat;

  // Q2 rotates by -90 degrees, Q3 by 180 degrees; only negations actually used can saturate.
  always_comb begin
    fold_x   = s1_x_q;
    fold_y   = s1_y_q;
    fold_sat = 1'b0;
    case (s1_quad_q)
      QUAD_2: begin
        fold_x   = s1_y_q;
        fold_y   = neg_x;
        fold_sat = neg_x_sat;
      end
      QUAD_3: begin
        fold_x   = neg_x;
        fold_y   = neg_y;
        fold_sat = neg_x_sat | neg_y_sat;
      end
      default: ;
    endcase
  end

  // Stage 2: fold result held stable while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      x_map_q    <= '0;
      y_map_q    <= '0;
      quad_q     <= QUAD_1;
      sat_flag_q <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        x_map_q    <= fold_x;
        y_map_q    <= fold_y;
        quad_q     <= s1_quad_q;
        sat_flag_q <= fold_sat;
      end
    end
  end

  always_comb begin
    sat_count_d = sat_count_q;
    if (out_xfer && sat_flag_q && (sat_count_q != 16'hFFFF)) begin
      sat_count_d = sat_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_count_q <= '0;
    end else begin
      sat_count_q <= sat_count_d;
    end
  end

  assign out_valid    = s2_valid_q;
  assign x_map        = x_map_q;
  assign y_map        = y_map_q;
  assign quadrant_loc = quad_q;
  assign sat_flag     = sat_flag_q;
  assign sat_count    = sat_count_q;

endmodule

// File: tb/tb_cordic_input_mapping.sv
// Scoreboard bench for cordic_input_mapping: directed vectors, back-pressure, wrap mode, reset flush.
module tb_cordic_input_mapping;

  localparam int W = 20;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                in_valid, in_ready, out_valid, out_ready, sat_flag;
  logic signed [W-1:0] x_in, y_in, x_map, y_map;
  logic [2:0]          quadrant_loc;
  logic [15:0]         sat_count;

  logic                w_in_valid, w_in_ready, w_out_valid, w_sat_flag;
  logic signed [W-1:0] w_x_in, w_y_in, w_x_map, w_y_map;
  logic [2:0]          w_quad;
  logic [15:0]         w_sat_count;

  cordic_input_mapping #(.W(W), .SAT_EN(1'b1)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .x_in         (x_in),
    .y_in         (y_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .x_map        (x_map),
    .y_map        (y_map),
    .quadrant_loc (quadrant_loc),
    .sat_flag     (sat_flag),
    .sat_count    (sat_count)
  );

  cordic_input_mapping #(.W(W), .SAT_EN(1'b0)) u_dut_wrap (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (w_in_valid),
    .in_ready     (w_in_ready),
    .x_in         (w_x_in),
    .y_in         (w_y_in),
    .out_valid    (w_out_valid),
    .out_ready    (1'b1),
    .x_map        (w_x_map),
    .y_map        (w_y_map),
    .quadrant_loc (w_quad),
    .sat_flag     (w_sat_flag),
    .sat_count    (w_sat_count)
  );

  typedef struct {
    int x, y, ex, ey, eq, es;
  } beat_t;

  beat_t sb[$];
  int total = 0;
  int bad = 0;
  int sb_satcnt = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input int x, input int y, input int ex, input int ey,
                      input int eq, input int es);
    int budget;
    beat_t b;
    b = '{x: x, y: y, ex: ex, ey: ey, eq: eq, es: es};
    in_valid = 1'b1;
    x_in = x[W-1:0];
    y_in = y[W-1:0];
    budget = 0;
    @(negedge clk);
    while (!in_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 50 cycles");
    end else begin
      sb.push_back(b);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int budget = 0;
    while (sb.size() != 0 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    check("drain_empty", sb.size(), 0);
    @(negedge clk);
  endtask

  // Monitor: pops on every output transfer and checks stability during stalls.
  logic                stalled = 1'b0;
  logic signed [W-1:0] hx, hy;
  logic [2:0]          hq;
  logic                hs;

  always @(negedge clk) begin
    beat_t e;
    int rx, ry;
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid", int'(out_valid), 1);
        check("stall_x", x_map, hx);
        check("stall_y", y_map, hy);
        check("stall_q", int'(quadrant_loc), int'(hq));
        check("stall_sat", int'(sat_flag), int'(hs));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got beat x=%0d y=%0d expected none", x_map, y_map);
        end else begin
          e = sb.pop_front();
          check("x_map", x_map, e.ex);
          check("y_map", y_map, e.ey);
          check("quadrant", int'(quadrant_loc), e.eq);
          check("sat_flag", int'(sat_flag), e.es);
          check("sat_count", int'(sat_count), sb_satcnt);
          if (e.es != 0) sb_satcnt++;
          else begin
            // Output mapper inverse of the fold must restore the original vector.
            rx = x_map;
            ry = y_map;
            if (e.eq == 2) begin
              rx = -int'(y_map);
              ry = x_map;
            end else if (e.eq == 3) begin
              rx = -int'(x_map);
              ry = -int'(y_map);
            end
            check("roundtrip_x", rx, e.x);
            check("roundtrip_y", ry, e.y);
          end
        end
      end
      stalled = out_valid && !out_ready;
      hx = x_map;
      hy = y_map;
      hq = quadrant_loc;
      hs = sat_flag;
    end
  end

  int vx[10] = '{100, -100, -100, 100, 0, 0, -7, -524288, -524288, 3};
  int vy[10] = '{50, 50, -50, -50, 0, -7, 0, -1, 5, 4};
  int ex[10] = '{100, 50, 100, 100, 0, 0, 0, 524287, 5, 3};
  int ey[10] = '{50, 100, 50, -50, 0, -7, 7, 1, 524287, 4};
  int eq[10] = '{1, 2, 3, 4, 1, 4, 2, 3, 2, 1};
  int es[10] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0};

  int bx[5] = '{1, -3, -5, 7, 9};
  int by[5] = '{2, 4, -6, -8, 10};
  int bex[5] = '{1, 4, 5, 7, 9};
  int bey[5] = '{2, 3, 6, -8, 10};
  int beq[5] = '{1, 2, 3, 4, 1};

  initial begin
    int budget;
    rst = 1'b1;
    in_valid = 1'b0;
    x_in = '0;
    y_in = '0;
    out_ready = 1'b1;
    w_in_valid = 1'b0;
    w_x_in = '0;
    w_y_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_x_map", x_map, 0);
    check("rst_y_map", y_map, 0);
    check("rst_quadrant", int'(quadrant_loc), 1);
    check("rst_sat_flag", int'(sat_flag), 0);
    check("rst_sat_count", int'(sat_count), 0);
    check("rst_in_ready", int'(in_ready), 1);

    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) send(vx[i], vy[i], ex[i], ey[i], eq[i], es[i]);
    drain();
    check("sat_count_after_vectors", int'(sat_count), 2);

    // Back-pressure: consumer stalls while five beats stream in.
    @(posedge clk);
    #1 out_ready = 1'b0;
    fork
      for (int i = 0; i < 5; i++) send(bx[i], by[i], bex[i], bey[i], beq[i], 0);
      begin
        repeat (4) @(negedge clk);
        check("bp_in_ready_low", int'(in_ready), 0);
        check("bp_out_valid_held", int'(out_valid), 1);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Wrap mode: most-negative value negates to itself but still flags.
    check("wrap_in_ready", int'(w_in_ready), 1);
    @(posedge clk);
    #1;
    w_in_valid = 1'b1;
    w_x_in = -20'sd524288;
    w_y_in = -20'sd1;
    @(posedge clk);
    #1 w_in_valid = 1'b0;
    budget = 0;
    @(negedge clk);
    while (!w_out_valid && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    check("wrap_out_valid", int'(w_out_valid), 1);
    check("wrap_x_map", w_x_map, -524288);
    check("wrap_y_map", w_y_map, 1);
    check("wrap_quadrant", int'(w_quad), 3);
    check("wrap_sat_flag", int'(w_sat_flag), 1);

    // Reset with two beats in flight flushes both stages.
    @(posedge clk);
    #1;
    send(11, 12, 11, 12, 1, 0);
    send(-13, 14, 14, 13, 2, 0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    sb_satcnt = 0;
    @(negedge clk);
    check("flush_out_valid", int'(out_valid), 0);
    check("flush_sat_count", int'(sat_count), 0);
    check("flush_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    send(-15, -16, 15, 16, 3, 0);
    @(negedge clk);
    check("latency_cycle1", int'(out_valid), 0);
    @(negedge clk);
    check("latency_cycle2", int'(out_valid), 1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
